// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types and helpers for the
// multi-channel integer clock divider.
package clkdiv_pkg;

  localparam int CH_DEF = 4;
  localparam int W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Ratios below 2 cannot produce a divided clock.
  function automatic logic ratio_ok(
    input logic [31:0] r
  );
    return r >= 32'd2;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel, period R,
// high ceil(R/2), changes only at boundaries.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_i,
  input  logic         en_i,
  input  logic [W-1:0] ratio_i,
  output logic         clk_o,
  output logic         tick_o,
  output logic         active_o
);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_q, cur_d;
  logic         out_q, out_d;
  logic         tick_q, tick_d;

  logic [W:0]   hi;
  logic [W-1:0] cnt_inc;
  logic         last;
  logic         go;
  logic         bound;

  // Next-state: restart or stop at boundaries, else advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    out_d   = out_q;
    tick_d  = 1'b0;
    hi      = ({1'b0, cur_q} + {{W{1'b0}}, 1'b1}) >> 1;
    cnt_inc = cnt_q + {{(W-1){1'b0}}, 1'b1};
    last    = (cnt_q == (cur_q - {{(W-1){1'b0}}, 1'b1}));
    go      = en_i && ratio_ok(32'(ratio_i));
    bound   = sync_i || (state_q == IDLE) || last;
    if (bound) begin
      if (go) begin
        state_d = RUN;
        cnt_d   = '0;
        cur_d   = ratio_i;
        out_d   = 1'b1;
        tick_d  = 1'b1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    end else begin
      cnt_d = cnt_inc;
      out_d = ({1'b0, cnt_inc} < hi);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign clk_o    = out_q;
  assign tick_o   = tick_q;
  assign active_o = (state_q == RUN);

endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: CH independent dividers sharing
// reset and the phase-alignment strobe.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int W  = W_DEF
) (
  input  logic          I_ref_clk,
  input  logic          I_rst,
  input  logic [CH-1:0] I_clk_en,
  input  logic [CH*W-1:0] I_div_ratio,
  input  logic          I_sync,
  output logic [CH-1:0] O_clk_out,
  output logic [CH-1:0] O_tick,
  output logic [CH-1:0] O_active
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    clkdiv_chan #(
      .W(W)
    ) u_chan (
      .clk     (I_ref_clk),
      .rst     (I_rst),
      .sync_i  (I_sync),
      .en_i    (I_clk_en[c]),
      .ratio_i (I_div_ratio[c*W +: W]),
      .clk_o   (O_clk_out[c]),
      .tick_o  (O_tick[c]),
      .active_o(O_active[c])
    );
  end

endmodule
